// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters for decode hazard stalls.
// Decode stalls on reads of registers with writes in flight, or when rd's counter is full.
`default_nettype none

module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 7
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             IssueValid,
    input  logic [4:0]       IssueRs1,
    input  logic [4:0]       IssueRs2,
    input  logic             IssueUsesRs1,
    input  logic             IssueUsesRs2,
    input  logic             IssueWritesRd,
    input  logic [4:0]       IssueRd,
    input  logic             WbValid,
    input  logic [4:0]       WbRd,
    output logic             Stall,
    output logic [NREG-1:0]  Busy,
    output logic [TOT_W-1:0] PendingTotal,
    output logic             Underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic [TOT_W-1:0] tot;
    logic [NREG-1:0]  busy_vec;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             hazard_rs1;
    logic             hazard_rs2;
    logic             hazard_rd;
    logic             accept;
    logic             inc_eff;
    logic             dec_eff;
    logic             underflow_evt;

    // x0 is never reported busy, whatever its storage holds.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (r != 0) && (cnt[r] != '0);
        end
    end

    always_comb begin
        hazard_rs1 = IssueUsesRs1 && (IssueRs1 != 5'd0) && busy_vec[IssueRs1];
        hazard_rs2 = IssueUsesRs2 && (IssueRs2 != 5'd0) && busy_vec[IssueRs2];
        hazard_rd  = IssueWritesRd && (IssueRd != 5'd0) && (cnt[IssueRd] == CNT_MAX);
        Stall      = IssueValid && (hazard_rs1 || hazard_rs2 || hazard_rd);
        accept     = IssueValid && !Stall;

        inc_vec = '0;
        if (accept && IssueWritesRd && (IssueRd != 5'd0)) begin
            inc_vec[IssueRd] = 1'b1;
        end
        dec_vec = '0;
        if (WbValid && (WbRd != 5'd0)) begin
            dec_vec[WbRd] = 1'b1;
        end

        // An issue and a writeback to the same register cancel out, even at zero.
        inc_eff       = |(inc_vec & ~dec_vec);
        dec_eff       = |(dec_vec & ~inc_vec & busy_vec);
        underflow_evt = |(dec_vec & ~inc_vec & ~busy_vec);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            tot       <= '0;
            Underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && busy_vec[r]) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            tot       <= tot + TOT_W'(inc_eff) - TOT_W'(dec_eff);
            Underflow <= Underflow | underflow_evt;
        end
    end

    assign Busy         = busy_vec;
    assign PendingTotal = tot;

endmodule

`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 32 architectural registers of the pipelined RISC-V core.
- Sits beside the decode stage, which reads the register file, and is fed by the writeback path, which writes it.
- Decode presents each instruction's source and destination registers. The block asserts Stall when a source register still has a write outstanding, or when the destination's counter is saturated.
- Writeback retires one pending write per cycle, mirroring the register file's write port.

Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired and never tracked.
- CNT_W, 2, width of each per-register pending counter; MAX = 2^CNT_W - 1 = 3 outstanding writes per register.
- TOT_W, 7, width of PendingTotal; must satisfy 2^TOT_W > (NREG-1)*MAX.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears all state on the Clock edge where it is high.
- IssueValid  in  1  decode presents an instruction this cycle.
- IssueRs1  in  5  source register 1 index.
- IssueRs2  in  5  source register 2 index.
- IssueUsesRs1  in  1  instruction reads rs1.
- IssueUsesRs2  in  1  instruction reads rs2.
- IssueWritesRd  in  1  instruction writes rd.
- IssueRd  in  5  destination register index.
- WbValid  in  1  writeback commits a register write this cycle (same signal as the register file's RegWrite).
- WbRd  in  5  writeback destination index (same as the register file's WriteReg).
- Stall  out  1  combinational; decode must hold the instruction when high.
- Busy  out  NREG  Busy[r] = (cnt[r] != 0); Busy[0] is always 0.
- PendingTotal  out  TOT_W  sum of all cnt[r]; registered.
- Underflow  out  1  sticky error: a writeback arrived with no pending write to retire.

Behaviour:
- State:
  - cnt[1..31], each CNT_W bits.
  - tot, TOT_W bits.
  - Underflow flag.
  - cnt[0] is constant 0.
- Reset, synchronous, priority over all else: every cnt = 0, tot = 0, Underflow = 0. Busy and PendingTotal read 0 in the cycle after the reset edge.
- Stall is combinational and asserted when IssueValid && (A || B || C):
  - A = IssueUsesRs1 && IssueRs1 != 0 && cnt[IssueRs1] != 0.
  - B = IssueUsesRs2 && IssueRs2 != 0 && cnt[IssueRs2] != 0.
  - C = IssueWritesRd && IssueRd != 0 && cnt[IssueRd] == MAX.
- There is no same-cycle writeback bypass. A writeback retiring the last pending write to rs1 in cycle N does not clear Stall in cycle N; Stall drops in cycle N+1. This matches the register file, which reads combinationally and writes at the clock edge.
- Stall is 0 whenever IssueValid is 0.
- Accept = IssueValid && !Stall.
- inc_r = Accept && IssueWritesRd && IssueRd == r && r != 0.
- dec_r = WbValid && WbRd == r && r != 0.
- Per-register update each edge:
  - inc only: cnt +1.
  - dec only with cnt != 0: cnt -1.
  - dec only with cnt == 0: cnt stays 0; Underflow <= 1.
  - inc and dec together: cnt unchanged, no Underflow, including when cnt == 0.
  - neither: hold.
- Writes to x0 (IssueRd = 0 or WbRd = 0) are ignored completely: no counter change, no Stall contribution, no Underflow.
- tot tracks the sum of cnt every cycle: +1 on an effective inc, -1 on an effective dec, unchanged on a net-zero cycle or an underflow event. Issue and writeback to different registers in the same cycle leave tot unchanged.
- Overflow is impossible by construction (C blocks an inc at MAX). Implementations must not wrap.
- An instruction may read and write the same register (rs1 == rd). Only the source check (A) uses the pre-edge counter; the increment happens on accept.
- Underflow clears only on Reset.
- Reset asserted mid-operation discards all pending state. Writebacks arriving after Reset for pre-reset issues set Underflow, which is the expected diagnostic.

Test Plan:
- Reset high 2 cycles with random inputs -> Busy = 0, PendingTotal = 0, Underflow = 0, Stall = 0 whenever IssueValid = 0.
- Issue rd = 5 (IssueWritesRd = 1, no sources), then next cycle issue with rs1 = 5 -> Stall = 1.
  - WbValid with WbRd = 5 in cycle N -> Stall still 1 in N, 0 in N+1.
  - Busy[5] goes 1 then 0; PendingTotal goes 1 then 0.
- Issue rd = 7 three times on consecutive cycles -> cnt[7] = 3, PendingTotal = 3.
  - A fourth issue to rd = 7 -> Stall = 1 and cnt stays 3.
  - One WbRd = 7 -> the fourth issue is accepted next cycle; cnt[7] returns to 3.
- Same-cycle issue rd = 9 and WbRd = 9 with cnt[9] = 1 -> cnt[9] stays 1, PendingTotal unchanged, Underflow = 0.
  - Also issue rd = 3 with WbRd = 9 -> PendingTotal unchanged, Busy[3] = 1.
- Issue rd = 0 and WbRd = 0, with rs1 = 0 and IssueUsesRs1 = 1 -> Stall = 0, Busy = 0, PendingTotal = 0, Underflow = 0.
- WbRd = 12 with cnt[12] = 0 -> Underflow = 1 and stays 1 through later traffic; Reset -> Underflow = 0.
